flt_best_tracker: RTL and testbench

- Fastest-lap tracker: each cycle may carry one (id, time) entry from up to three sources.
- Keeps the smallest time seen since reset, together with the id that produced it.
- Sits after the timing front-end and feeds the scoreboard/display path with registered outputs.

---
 rtl/flt_pkg.sv | 16 +
 rtl/flt_cmp.sv | 33 +++
 rtl/flt_best_tracker.sv | 49 ++++
 tb/tb_flt_best_tracker.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/flt_pkg.sv
// flt_pkg: shared widths, sentinels and entry bundle for the best-lap tracker.
// Optional build macro used by this slice: FLT_TIE_LATEST_EN.
package flt_pkg;

    localparam int FLT_NW = 2;
    localparam int FLT_TW = 8;

    localparam logic [FLT_NW-1:0] ID_NONE = '0;
    localparam logic [FLT_TW-1:0] T_NONE  = '1;

    typedef struct packed {
        logic [FLT_NW-1:0] id;
        logic [FLT_TW-1:0] tm;
    } entry_t;

endpackage

// File: rtl/flt_cmp.sv
// flt_cmp: decides whether a candidate entry displaces the current best.
// FLT_TIE_LATEST_EN: an equal time also takes the title (latest source wins).
module flt_cmp
    import flt_pkg::*;
#(
    parameter int NW = FLT_NW,
    parameter int TW = FLT_TW
) (
    input  logic [NW-1:0] i_n,
    input  logic [TW-1:0] i_t,
    input  logic [TW-1:0] i_t_best,
    input  logic          i_have,
    output logic          o_upd
);

    // Update strobe: first entry always wins, then strictly faster times.
    // Comparison is gated by i_n so a junk time on an idle cycle is ignored.
    always_comb begin
        o_upd = 1'b0;
        if (i_n != '0) begin
            if (!i_have) begin
                o_upd = 1'b1;
            end else if (i_t < i_t_best) begin
                o_upd = 1'b1;
`ifdef FLT_TIE_LATEST_EN
            end else if (i_t == i_t_best) begin
                o_upd = 1'b1;
`endif
            end
        end
    end

endmodule

// File: rtl/flt_best_tracker.sv
// flt_best_tracker: registered minimum-time tracker with the owning id.
// Tie policy selected by FLT_TIE_LATEST_EN (undefined: earlier holder keeps it).
module flt_best_tracker
    import flt_pkg::*;
#(
    parameter int NW = FLT_NW,
    parameter int TW = FLT_TW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [NW-1:0] n,
    input  logic [TW-1:0] t,
    output logic [NW-1:0] n_best,
    output logic [TW-1:0] t_best
);

    logic [NW-1:0] r_n_best;
    logic [TW-1:0] r_t_best;
    logic          r_have;
    logic          w_upd;

    flt_cmp #(
        .NW (NW),
        .TW (TW)
    ) u_cmp (
        .i_n      (n),
        .i_t      (t),
        .i_t_best (r_t_best),
        .i_have   (r_have),
        .o_upd    (w_upd)
    );

    // Record register: sync active-low clear, load on comparator strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_n_best <= '0;
            r_t_best <= '1;
            r_have   <= 1'b0;
        end else if (w_upd) begin
            r_n_best <= n;
            r_t_best <= t;
            r_have   <= 1'b1;
        end
    end

    assign n_best = r_n_best;
    assign t_best = r_t_best;

endmodule

// File: tb/tb_flt_best_tracker.sv
// tb_flt_best_tracker: directed vectors plus a short random run,
// expected values queued by the driver and checked by a separate monitor.
module tb_flt_best_tracker;
    import flt_pkg::*;

`ifdef FLT_TIE_LATEST_EN
    localparam bit TIE = 1'b1;
`else
    localparam bit TIE = 1'b0;
`endif

    typedef struct {
        entry_t e;
        int     idx;
    } exp_t;

    logic              clk;
    logic              reset;
    logic [FLT_NW-1:0] n;
    logic [FLT_TW-1:0] t;
    logic [FLT_NW-1:0] n_best;
    logic [FLT_TW-1:0] t_best;

    exp_t q[$];
    int   tests;
    int   fails;
    int   step;

    flt_best_tracker dut (
        .clk    (clk),
        .reset  (reset),
        .n      (n),
        .t      (t),
        .n_best (n_best),
        .t_best (t_best)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus and queue the value expected after the edge.
    task automatic drive(input bit rst, input logic [FLT_NW-1:0] vn,
                         input logic [FLT_TW-1:0] vt,
                         input logic [FLT_NW-1:0] en,
                         input logic [FLT_TW-1:0] et);
        exp_t x;
        @(negedge clk);
        reset = ~rst;
        n     = vn;
        t     = vt;
        x.e.id = en;
        x.e.tm = et;
        x.idx  = step;
        q.push_back(x);
        step++;
    endtask

    // Monitor: outputs are registered, so sample just after each rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                tests++;
                if (n_best !== x.e.id || t_best !== x.e.tm) begin
                    fails++;
                    $display("FAIL step%0d: got %0d/%0d expected %0d/%0d",
                             x.idx, n_best, t_best, x.e.id, x.e.tm);
                end
            end
        end
    end

    initial begin
        logic [FLT_NW-1:0] mn;
        logic [FLT_TW-1:0] mt;
        logic [FLT_NW-1:0] rn;
        logic [FLT_TW-1:0] rt;
        bit                mh;
        bit                rr;
        tests = 0;
        fails = 0;
        step  = 0;
        reset = 1'b0;
        n     = '0;
        t     = '0;

        // reset, then idle with junk time
        drive(1, 0, 8'h33, ID_NONE, T_NONE);
        drive(0, 0, 8'h5a, ID_NONE, T_NONE);
        // main sequence
        drive(0, 1, 128, 1, 128);
        drive(0, 2, 127, 2, 127);
        drive(0, 3, 129, 2, 127);
        drive(0, 0, 8'hxx, 2, 127);
        drive(0, 2, 126, 2, 126);
        drive(0, 2, 129, 2, 126);
        drive(0, 1, 124, 1, 124);
        drive(0, 3, 124, TIE ? 2'd3 : 2'd1, 124);
        drive(0, 1, 125, TIE ? 2'd3 : 2'd1, 124);
        drive(0, 2, 126, TIE ? 2'd3 : 2'd1, 124);
        // reset beats a simultaneous entry; first entry after wins at 255
        drive(1, 1, 10, ID_NONE, T_NONE);
        drive(0, 3, 255, 3, 255);
        // saturation at zero
        drive(0, 2, 0, 2, 0);
        drive(0, 1, 0, TIE ? 2'd1 : 2'd2, 0);
        drive(0, 3, 5, TIE ? 2'd1 : 2'd2, 0);

        // random run against a min-tracking model
        mn = ID_NONE;
        mt = T_NONE;
        mh = 1'b0;
        for (int i = 0; i < 28; i++) begin
            rr = (i == 0);
            rn = FLT_NW'($urandom_range(0, 3));
            rt = FLT_TW'($urandom_range(0, 255));
            if (i > 0 && i < 4) rt = FLT_TW'($urandom_range(200, 255));
            if (rr) begin
                mn = ID_NONE;
                mt = T_NONE;
                mh = 1'b0;
            end else if (rn != 0) begin
                if (!mh || rt < mt || (TIE && rt == mt)) begin
                    mn = rn;
                    mt = rt;
                    mh = 1'b1;
                end
            end
            drive(rr, rn, rt, mn, mt);
        end

        // let the monitor drain, bounded
        for (int k = 0; k < 4 && q.size() > 0; k++) begin
            @(posedge clk);
            #2;
        end
        if (q.size() > 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
